// File: rtl/uart_tx_if.sv
// Host-side handshake bundle for the serial transmitter: start/data in, busy/done/line out.
interface uart_tx_if #(
  parameter int NUM_DATA_BITS = 8
);
  logic                     tx_start;
  logic [NUM_DATA_BITS-1:0] tx_data;
  logic                     tx_busy;
  logic                     tx_done;
  logic                     serial_out;

  modport master (
    output tx_start,
    output tx_data,
    input  tx_busy,
    input  tx_done,
    input  serial_out
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx_busy,
    output tx_done,
    output serial_out
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, stop bit; CLKS_PER_BIT clocks per bit.
// All outputs registered; tx_start is only honoured in IDLE (no queueing while busy).
module uart_tx #(
  parameter int CLKS_PER_BIT  = 10,
  parameter int NUM_DATA_BITS = 8,
  parameter int CNT_BITS      = 4
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam int IDX_BITS = (NUM_DATA_BITS > 1) ? $clog2(NUM_DATA_BITS) : 1;
  // The bit-period counter holds (count - 1), so a count of 1..2**CNT_BITS fits in CNT_BITS.
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(CLKS_PER_BIT - 1);
  localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(NUM_DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                   state_q,   state_d;
  logic [CNT_BITS-1:0]      bit_cnt_q, bit_cnt_d;
  logic [IDX_BITS-1:0]      bit_idx_q, bit_idx_d;
  logic [NUM_DATA_BITS-1:0] shreg_q,   shreg_d;
  logic                     serial_q,  serial_d;
  logic                     busy_q,    busy_d;
  logic                     done_q,    done_d;
  logic                     bit_end;

  assign bit_end = (bit_cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      serial_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      serial_q  <= serial_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_end ? '0 : bit_cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    serial_d  = serial_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        serial_d  = 1'b1;
        busy_d    = 1'b0;
        bit_cnt_d = '0;
        if (bus.tx_start) begin
          shreg_d   = bus.tx_data;
          bit_idx_d = '0;
          state_d   = START;
          serial_d  = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d  = DATA;
          serial_d = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_idx_q == IDX_LAST) begin
            state_d  = STOP;
            serial_d = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            serial_d  = shreg_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  assign bus.serial_out = serial_q;
  assign bus.tx_busy    = busy_q;
  assign bus.tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table vectors, corner sequences and random traffic vs a frame model.
module tb_uart_tx;

  localparam int C1 = 10;
  localparam int N1 = 8;
  localparam int F1 = (N1 + 2) * C1;
  localparam int C2 = 16;
  localparam int N2 = 7;
  localparam int F2 = (N2 + 2) * C2;

  logic clk = 1'b0;
  logic rst;

  uart_tx_if #(.NUM_DATA_BITS(N1)) i1 ();
  uart_tx_if #(.NUM_DATA_BITS(N2)) i2 ();

  uart_tx #(.CLKS_PER_BIT(C1), .NUM_DATA_BITS(N1), .CNT_BITS(4)) d1 (
    .clk(clk), .rst(rst), .bus(i1.slave)
  );
  uart_tx #(.CLKS_PER_BIT(C2), .NUM_DATA_BITS(N2), .CNT_BITS(4)) d2 (
    .clk(clk), .rst(rst), .bus(i2.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Frame model for d1: a frame is just an offset into a (N+2)*C cycle window.
  bit         m_act  = 1'b0;
  int         m_off  = 0;
  logic [7:0] m_data = '0;
  bit         m_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act  = 1'b0;
      m_off  = 0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_act) begin
        m_off++;
        if (m_off == F1) begin
          m_act  = 1'b0;
          m_done = 1'b1;
        end
      end else if (i1.tx_start === 1'b1) begin
        m_act  = 1'b1;
        m_off  = 0;
        m_data = i1.tx_data;
      end
    end
  end

  function automatic logic exp_line(input int off, input logic [7:0] d);
    int b;
    b = off / C1;
    if (b == 0) return 1'b0;
    if (b <= N1) return d[b-1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    chk("model_line", i1.serial_out, m_act ? exp_line(m_off, m_data) : 1'b1);
    chk("model_busy", i1.tx_busy, m_act);
    chk("model_done", i1.tx_done, m_done);
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;
  } vec_t;

  vec_t tbl [5];

  task automatic send1(input logic [7:0] d);
    @(negedge clk);
    i1.tx_start = 1'b1;
    i1.tx_data  = d;
    @(negedge clk);
    i1.tx_start = 1'b0;
  endtask

  // Called from inside cycle E0; walks the whole frame up to the done cycle.
  task automatic check_frame1(input string tag, input logic [9:0] bits);
    int busy_cnt = 0;
    int done_at  = -1;
    for (int k = 0; k <= F1; k++) begin
      if (k % C1 == C1 / 2)
        chk($sformatf("%s_bit%0d", tag, k / C1), i1.serial_out, bits[k / C1]);
      if (i1.tx_busy) busy_cnt++;
      if (i1.tx_done) done_at = k;
      if (k < F1) @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, busy_cnt, F1);
    chk({tag, "_done_cycle"}, done_at, F1);
  endtask

  task automatic wait_idle1(input string tag);
    int n = 0;
    while (i1.tx_busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle_timeout"}, i1.tx_busy, 1'b0);
  endtask

  task automatic wait_done1(input string tag, output int t);
    int n = 0;
    t = -1;
    while (i1.tx_done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_timeout"}, i1.tx_done, 1'b1);
    t = cyc;
  endtask

  initial begin
    int t1, t2, dones, busy_cnt, done_at;
    logic [8:0] bits2;

    tbl[0] = '{8'hA5, 10'b1101001010};
    tbl[1] = '{8'h00, 10'b1000000000};
    tbl[2] = '{8'hFF, 10'b1111111110};
    tbl[3] = '{8'h3C, 10'b1001111000};
    tbl[4] = '{8'h81, 10'b1100000010};

    rst = 1'b1;
    i1.tx_start = 1'b0; i1.tx_data = '0;
    i2.tx_start = 1'b0; i2.tx_data = '0;
    #1;
    chk("rst0_line", i1.serial_out, 1'b1);
    chk("rst0_busy", i1.tx_busy, 1'b0);
    chk("rst0_done", i1.tx_done, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset mid-frame, between clock edges.
    send1(8'h00);
    repeat (30) @(negedge clk);
    chk("pre_rst_busy", i1.tx_busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_line", i1.serial_out, 1'b1);
    chk("async_rst_busy", i1.tx_busy, 1'b0);
    chk("async_rst_done", i1.tx_done, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      send1(tbl[v].data);
      check_frame1($sformatf("vec%0d", v), tbl[v].bits);
      repeat (3) @(negedge clk);
    end

    // tx_start with new data while busy is ignored.
    send1(8'h3C);
    repeat (40) @(negedge clk);
    i1.tx_start = 1'b1; i1.tx_data = 8'hFF;
    @(negedge clk);
    i1.tx_start = 1'b0; i1.tx_data = 8'h5A;
    dones = 0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (i1.tx_done) dones++;
    end
    chk("ignore_start_dones", dones, 1);
    chk("ignore_start_idle", i1.tx_busy, 1'b0);

    // Start in the done cycle: back-to-back frames.
    send1(8'h00);
    wait_done1("b2b_first", t1);
    i1.tx_start = 1'b1; i1.tx_data = 8'hFF;
    @(negedge clk);
    i1.tx_start = 1'b0;
    chk("b2b_start_bit", i1.serial_out, 1'b0);
    chk("b2b_busy", i1.tx_busy, 1'b1);
    wait_done1("b2b_second", t2);
    chk("b2b_done_gap", t2 - t1, F1 + 1);

    // Reset at cycle 55 of a 0x81 frame; nothing resumes afterwards.
    send1(8'h81);
    repeat (55) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst55_line", i1.serial_out, 1'b1);
    chk("rst55_busy", i1.tx_busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    busy_cnt = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (i1.tx_done) dones++;
      if (i1.tx_busy) busy_cnt++;
    end
    chk("rst55_no_done", dones, 0);
    chk("rst55_no_busy", busy_cnt, 0);
    send1(8'h81);
    check_frame1("rst55_new", tbl[4].bits);

    // Second instance: 16 clocks per bit, 7 data bits.
    bits2 = {1'b1, 7'h55, 1'b0};
    @(negedge clk);
    i2.tx_start = 1'b1; i2.tx_data = 7'h55;
    @(negedge clk);
    i2.tx_start = 1'b0; i2.tx_data = 7'h2A;
    busy_cnt = 0;
    done_at = -1;
    for (int k = 0; k <= F2; k++) begin
      if (k % C2 == C2 / 2)
        chk($sformatf("p16_bit%0d", k / C2), i2.serial_out, bits2[k / C2]);
      if (i2.tx_busy) busy_cnt++;
      if (i2.tx_done) done_at = k;
      if (k < F2) @(negedge clk);
    end
    chk("p16_busy_cycles", busy_cnt, F2);
    chk("p16_done_cycle", done_at, F2);

    // Random traffic: gaps, multi-cycle start pulses, data churn mid-frame.
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      i1.tx_data  = 8'($urandom);
      i1.tx_start = 1'b1;
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk);
        i1.tx_data = 8'($urandom);
      end
      i1.tx_start = 1'b0;
      repeat ($urandom_range(0, 60)) @(negedge clk);
      i1.tx_data = 8'($urandom);
      wait_idle1("rand");
    end

    // tx_start held high: frames repeat back-to-back with fresh data at each accept.
    i1.tx_start = 1'b1;
    for (int k = 0; k < 350; k++) begin
      @(negedge clk);
      i1.tx_data = 8'($urandom);
    end
    i1.tx_start = 1'b0;
    wait_idle1("held");
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
